// File: rtl/ascii_hex_parser.sv
// Streaming ASCII hex token parser: delimiter-separated hex digits -> WIDTH-bit values.
// Define ASCII_HEX_PREFIX_EN to accept a "0x"/"0X" prefix on tokens.
module ascii_hex_parser #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = $clog2(WIDTH/4+1)+1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_value,
  output logic [CW-1:0]    out_ndigits,
  output logic             out_overflow,
  output logic             err
);

  localparam int unsigned NIB = WIDTH/4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] SKIP = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  logic [1:0]       state, state_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [CW-1:0]    ndig, ndig_n;
  logic             ovf, ovf_n;
  logic [WIDTH-1:0] value_n;
  logic [CW-1:0]    nd_out_n;
  logic             ovf_out_n;
  logic             err_n;
  logic             accept;
  logic             is_digit;
  logic             is_delim;
  logic [3:0]       nib;
`ifdef ASCII_HEX_PREFIX_EN
  logic             pfx, pfx_n;
  logic             is_x;

  assign is_x = (in_data == 8'h78) || (in_data == 8'h58);
`endif

  assign accept   = in_valid && in_ready;
  assign is_delim = (in_data == 8'h20) || (in_data == 8'h09) || (in_data == 8'h0A) ||
                    (in_data == 8'h0D) || (in_data == 8'h2C);

  // Character classification and nibble decode
  always_comb begin
    is_digit = 1'b0;
    nib      = 4'd0;
    if (in_data >= 8'h30 && in_data <= 8'h39) begin
      is_digit = 1'b1;
      nib      = 4'(in_data - 8'h30);
    end else if (in_data >= 8'h41 && in_data <= 8'h46) begin
      is_digit = 1'b1;
      nib      = 4'(in_data - 8'h37);
    end else if (in_data >= 8'h61 && in_data <= 8'h66) begin
      is_digit = 1'b1;
      nib      = 4'(in_data - 8'h57);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    acc_n     = acc;
    ndig_n    = ndig;
    ovf_n     = ovf;
    value_n   = out_value;
    nd_out_n  = out_ndigits;
    ovf_out_n = out_overflow;
    err_n     = 1'b0;
`ifdef ASCII_HEX_PREFIX_EN
    pfx_n     = pfx;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_digit) begin
            acc_n   = WIDTH'(nib);
            ndig_n  = CW'(1);
            ovf_n   = 1'b0;
`ifdef ASCII_HEX_PREFIX_EN
            pfx_n   = 1'b0;
`endif
            state_n = ACC;
          end else if (!is_delim) begin
            err_n   = 1'b1;
            state_n = SKIP;
          end
        end
      end
      ACC: begin
        if (accept) begin
          if (is_digit) begin
            acc_n = (acc << 4) | WIDTH'(nib);
            if (ndig != {CW{1'b1}}) ndig_n = ndig + CW'(1);
            // a nonzero digit is about to fall off the top of the accumulator
            if (ndig >= CW'(NIB) && acc[WIDTH-1 -: 4] != 4'd0) ovf_n = 1'b1;
          end else if (is_delim) begin
`ifdef ASCII_HEX_PREFIX_EN
            if (pfx && ndig == '0) begin
              err_n   = 1'b1;
              state_n = IDLE;
            end else
`endif
            begin
              value_n   = acc;
              nd_out_n  = ndig;
              ovf_out_n = ovf;
              state_n   = HOLD;
            end
          end
`ifdef ASCII_HEX_PREFIX_EN
          else if (is_x && !pfx && ndig == CW'(1) && acc == '0) begin
            pfx_n  = 1'b1;
            ndig_n = '0;
          end
`endif
          else begin
            err_n   = 1'b1;
            state_n = SKIP;
          end
        end
      end
      SKIP: begin
        if (accept && is_delim) state_n = IDLE;
      end
      HOLD: begin
        if (out_valid && out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc          <= '0;
      ndig         <= '0;
      ovf          <= 1'b0;
      out_value    <= '0;
      out_ndigits  <= '0;
      out_overflow <= 1'b0;
      out_valid    <= 1'b0;
      in_ready     <= 1'b1;
      err          <= 1'b0;
`ifdef ASCII_HEX_PREFIX_EN
      pfx          <= 1'b0;
`endif
    end else begin
      acc          <= acc_n;
      ndig         <= ndig_n;
      ovf          <= ovf_n;
      out_value    <= value_n;
      out_ndigits  <= nd_out_n;
      out_overflow <= ovf_out_n;
      out_valid    <= (state_n == HOLD);
      in_ready     <= (state_n != HOLD);
      err          <= err_n;
`ifdef ASCII_HEX_PREFIX_EN
      pfx          <= pfx_n;
`endif
    end
  end

endmodule

// File: tb/tb_ascii_hex_parser.sv
// Randomized self-checking bench for ascii_hex_parser against a word-level reference model.
module tb_ascii_hex_parser;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned CW    = $clog2(WIDTH/4+1)+1;
  localparam int unsigned NIB   = WIDTH/4;
  localparam int          NDMAX = (1 << CW) - 1;

  typedef byte bq_t[$];
  typedef struct {
    logic [WIDTH-1:0] value;
    int               nd;
    bit               ovf;
  } tok_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_value;
  logic [CW-1:0]    out_ndigits;
  logic             out_overflow;
  logic             err;

  int total = 0;
  int bad   = 0;

  tok_t exp_q[$];
  bit   err_after[$];
  bit   tok_end[$];

  logic [WIDTH-1:0] last_value;
  logic [CW-1:0]    last_nd;
  logic             last_ovf;
  logic [WIDTH-1:0] dut_value;
  logic [CW-1:0]    dut_nd;
  logic             dut_ovf;
  int               dut_tok_cnt;
  int               err_cnt;
  int               cycles;

  ascii_hex_parser #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_value(out_value), .out_ndigits(out_ndigits), .out_overflow(out_overflow),
    .err(err)
  );

  always #5 clk = ~clk;

  function automatic bit is_hex(byte c);
    return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (c >= "a" && c <= "f");
  endfunction

  function automatic int hexval(byte c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    return int'(c) - 87;
  endfunction

  function automatic bit is_delim(byte c);
    return c == 8'h20 || c == 8'h09 || c == 8'h0A || c == 8'h0D || c == ",";
  endfunction

  function automatic bq_t s2q(string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // Reference: split the stream into words, judge each word as a whole
  task automatic model(input bq_t s);
    int n, i, st, en, start, badpos, sig;
    bit pfx, started;
    logic [WIDTH-1:0] v;
    tok_t t;
    n = s.size();
    exp_q = {}; err_after = {}; tok_end = {};
    for (int k = 0; k < n; k++) begin err_after.push_back(1'b0); tok_end.push_back(1'b0); end
    i = 0;
    while (i < n) begin
      if (is_delim(s[i])) begin i++; continue; end
      st = i; en = i;
      while (en < n && !is_delim(s[en])) en++;
      start = st; pfx = 1'b0; badpos = -1;
`ifdef ASCII_HEX_PREFIX_EN
      if (en - st >= 2 && s[st] == "0" && (s[st+1] == "x" || s[st+1] == "X")) begin
        pfx = 1'b1; start = st + 2;
      end
`endif
      for (int j = start; j < en; j++)
        if (badpos < 0 && !is_hex(s[j])) badpos = j;
      if (badpos >= 0) err_after[badpos] = 1'b1;
      else if (en < n && pfx && start == en) err_after[en] = 1'b1;
      else if (en < n) begin
        v = '0; sig = 0; started = 1'b0;
        for (int j = start; j < en; j++) begin
          v = v * 16 + WIDTH'(hexval(s[j]));
          if (hexval(s[j]) != 0) started = 1'b1;
          if (started) sig++;
        end
        t.value = v;
        t.nd    = (en - start > NDMAX) ? NDMAX : en - start;
        t.ovf   = (sig > NIB);
        exp_q.push_back(t);
        tok_end[en] = 1'b1;
      end
      i = en + 1;
    end
  endtask

  task automatic run_stream(input bq_t s, input int vpct, input int rpct, input string name);
    int idx, n, budget;
    bit acc, hs, pv, exp_valid, exp_err, te;
    tok_t t;
    model(s);
    n = s.size(); idx = 0; budget = 40 * n + 50;
    dut_tok_cnt = 0; err_cnt = 0; cycles = 0;
    while (!(idx == n && out_valid === 1'b0)) begin
      if (cycles >= budget) begin
        total++; bad++;
        $display("FAIL %s timeout: consumed %0d of %0d chars", name, idx, n);
        break;
      end
      in_valid  = (idx < n) && ($urandom_range(99, 0) < vpct);
      in_data   = (idx < n) ? s[idx] : 8'($urandom);
      out_ready = ($urandom_range(99, 0) < rpct);
      acc = in_valid && in_ready;
      pv  = out_valid;
      hs  = pv && out_ready;
      exp_err = acc ? err_after[idx] : 1'b0;
      te      = acc ? tok_end[idx] : 1'b0;
      @(posedge clk); #1;
      cycles++;
      total++;
      if (err !== exp_err) begin
        bad++; $display("FAIL %s err at char %0d: got %b want %b", name, idx, err, exp_err);
      end
      if (err === 1'b1) err_cnt++;
      exp_valid = te || (pv && !hs);
      total++;
      if (out_valid !== exp_valid) begin
        bad++; $display("FAIL %s out_valid at char %0d: got %b want %b", name, idx, out_valid, exp_valid);
      end
      total++;
      if (in_ready !== !exp_valid) begin
        bad++; $display("FAIL %s in_ready at char %0d: got %b want %b", name, idx, in_ready, !exp_valid);
      end
      if (te) begin
        t = exp_q.pop_front();
        last_value = t.value; last_nd = CW'(t.nd); last_ovf = t.ovf;
      end
      if (out_valid === 1'b1 && !pv) begin
        dut_tok_cnt++; dut_value = out_value; dut_nd = out_ndigits; dut_ovf = out_overflow;
      end
      total++;
      if (out_value !== last_value || out_ndigits !== last_nd || out_overflow !== last_ovf) begin
        bad++;
        $display("FAIL %s token fields: got %h/%0d/%b want %h/%0d/%b", name,
                 out_value, out_ndigits, out_overflow, last_value, last_nd, last_ovf);
      end
      if (acc) idx++;
    end
    in_valid = 1'b0;
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL %s tokens: %0d expected tokens never appeared", name, exp_q.size());
    end
  endtask

  task automatic check_reset_values(input string name);
    total++;
    if (out_valid !== 1'b0 || out_value !== '0 || out_ndigits !== '0 || out_overflow !== 1'b0 ||
        err !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s: got v=%b val=%h nd=%0d ovf=%b err=%b rdy=%b want 0/0/0/0/0/1", name,
               out_valid, out_value, out_ndigits, out_overflow, err, in_ready);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_values("post_reset_idle");
    last_value = '0; last_nd = '0; last_ovf = 1'b0;
  endtask

  task automatic test_vectors;
    string vec[9];
    int    etok[9], eerr[9], end_[9], eovf[9];
    logic [31:0] eval[9];
    vec[0] = "1A3f ";                       etok[0] = 1; eval[0] = 32'h1A3F;     end_[0] = 4;  eovf[0] = 0; eerr[0] = 0;
    vec[1] = "123456789\n";                 etok[1] = 1; eval[1] = 32'h23456789; end_[1] = 9;  eovf[1] = 1; eerr[1] = 0;
    vec[2] = "000000000ABCDEF1,";           etok[2] = 1; eval[2] = 32'h0ABCDEF1; end_[2] = 16; eovf[2] = 0; eerr[2] = 0;
    vec[3] = "12G4 5 ";                     etok[3] = 1; eval[3] = 32'h5;        end_[3] = 1;  eovf[3] = 0; eerr[3] = 1;
    vec[4] = "0x7f,";
`ifdef ASCII_HEX_PREFIX_EN
    etok[4] = 1; eval[4] = 32'h7F; end_[4] = 2; eovf[4] = 0; eerr[4] = 0;
`else
    etok[4] = 0; eval[4] = 32'h0;  end_[4] = 0; eovf[4] = 0; eerr[4] = 1;
`endif
    vec[5] = "0x,";                         etok[5] = 0; eval[5] = 32'h0;        end_[5] = 0;  eovf[5] = 0; eerr[5] = 1;
    vec[6] = "1111111111111111111111111111111111111111 ";
    etok[6] = 1; eval[6] = 32'h11111111; end_[6] = NDMAX; eovf[6] = 1; eerr[6] = 0;
    vec[7] = "\t,, a\r";                    etok[7] = 1; eval[7] = 32'hA;        end_[7] = 1;  eovf[7] = 0; eerr[7] = 0;
    vec[8] = "00000000000f ";               etok[8] = 1; eval[8] = 32'hF;        end_[8] = 12; eovf[8] = 0; eerr[8] = 0;
    for (int i = 0; i < 9; i++) begin
      run_stream(s2q(vec[i]), 75, 75, $sformatf("vec%0d", i));
      total++;
      if (dut_tok_cnt !== etok[i] || err_cnt !== eerr[i] ||
          (etok[i] != 0 && (dut_value !== eval[i] || dut_nd !== CW'(end_[i]) || dut_ovf !== eovf[i][0]))) begin
        bad++;
        $display("FAIL vec%0d: got tok=%0d err=%0d val=%h nd=%0d ovf=%b want tok=%0d err=%0d val=%h nd=%0d ovf=%0d",
                 i, dut_tok_cnt, err_cnt, dut_value, dut_nd, dut_ovf, etok[i], eerr[i], eval[i], end_[i], eovf[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    bq_t s;
    s = s2q("FF ");
    out_ready = 1'b0;
    foreach (s[i]) begin
      in_valid = 1'b1; in_data = s[i];
      @(posedge clk); #1;
    end
    // a pending character must not be consumed while the token is held
    in_data = "7";
    for (int i = 0; i < 10; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_value !== WIDTH'(32'hFF) || out_ndigits !== CW'(2) || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL backpressure hold cycle %0d: got v=%b val=%h nd=%0d rdy=%b want 1/ff/2/0",
                 i, out_valid, out_value, out_ndigits, in_ready);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL backpressure release: got v=%b rdy=%b want 0/1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_data = ",";
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_value !== WIDTH'(32'h7) || out_ndigits !== CW'(1) || out_overflow !== 1'b0) begin
      bad++;
      $display("FAIL backpressure next token: got v=%b val=%h nd=%0d ovf=%b want 1/7/1/0",
               out_valid, out_value, out_ndigits, out_overflow);
    end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL backpressure drain: got v=%b rdy=%b want 0/1", out_valid, in_ready);
    end
    last_value = WIDTH'(32'h7); last_nd = CW'(1); last_ovf = 1'b0;
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = "A";
    @(posedge clk); #1;
    in_data = "B";
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_values("reset_mid_assert");
    @(posedge clk); #1;
    check_reset_values("reset_mid_held");
    rst_n = 1'b1;
    last_value = '0; last_nd = '0; last_ovf = 1'b0;
    run_stream(s2q("C "), 100, 100, "reset_mid_after");
    total++;
    if (dut_tok_cnt !== 1 || dut_value !== WIDTH'(32'hC) || dut_nd !== CW'(1) || err_cnt !== 0) begin
      bad++;
      $display("FAIL reset_mid token: got tok=%0d val=%h nd=%0d err=%0d want 1/c/1/0",
               dut_tok_cnt, dut_value, dut_nd, err_cnt);
    end
  endtask

  task automatic test_back_to_back;
    run_stream(s2q("1 2 3 "), 100, 100, "b2b_tokens");
    total++;
    if (cycles !== 9 || dut_tok_cnt !== 3 || dut_value !== WIDTH'(32'h3)) begin
      bad++; $display("FAIL b2b_tokens: got cycles=%0d tok=%0d val=%h want 9/3/3", cycles, dut_tok_cnt, dut_value);
    end
    run_stream(s2q(",,, \n"), 100, 100, "b2b_delims");
    total++;
    if (cycles !== 5 || dut_tok_cnt !== 0 || err_cnt !== 0) begin
      bad++; $display("FAIL b2b_delims: got cycles=%0d tok=%0d err=%0d want 5/0/0", cycles, dut_tok_cnt, err_cnt);
    end
  endtask

  task automatic gen_stream(output bq_t q);
    string hexs, bads, dels;
    int ng, len, kind;
    hexs = "0123456789abcdefABCDEF";
    bads = "GZg!_.-xX@";
    dels = " \t\n\r,";
    q = {};
    ng = $urandom_range(6, 1);
    for (int g = 0; g < ng; g++) begin
      kind = $urandom_range(9, 0);
      len  = (kind == 4) ? $urandom_range(20, 6) : $urandom_range(8, 1);
      if (kind == 6) begin
        q.push_back("0");
        q.push_back(($urandom_range(1, 0) != 0) ? "x" : "X");
        len = $urandom_range(4, 0);
      end
      if (kind == 7) begin q.push_back("0"); q.push_back("0"); q.push_back("x"); end
      if (kind == 3) repeat ($urandom_range(8, 1)) q.push_back("0");
      for (int j = 0; j < len; j++) q.push_back(hexs[$urandom_range(21, 0)]);
      if (kind == 5) begin
        q.push_back(bads[$urandom_range(9, 0)]);
        q.push_back(hexs[$urandom_range(21, 0)]);
      end
      repeat ($urandom_range(3, 1)) q.push_back(dels[$urandom_range(4, 0)]);
    end
  endtask

  task automatic test_random;
    bq_t q;
    for (int k = 0; k < 40; k++) begin
      gen_stream(q);
      run_stream(q, $urandom_range(100, 30), $urandom_range(100, 30), $sformatf("rand%0d", k));
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ascii_hex_parser.md
# ascii_hex_parser

Streaming ASCII-to-binary hex token parser for the OSD/debug path. It is the inverse of the nibble-to-ASCII formatting used by the OSD writer. It consumes one ASCII character per handshake from a console or test stream, groups hex digits into delimiter-separated tokens, and emits each token as a WIDTH-bit value with digit count and overflow status. Malformed tokens are discarded with an error pulse.

## Interface
Parameters:
- WIDTH, 32: output value width in bits. Must be a multiple of 4 and at least 4.
- CW, $clog2(WIDTH/4+1)+1: width of the digit counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input character valid
- in_data  in  8  ASCII character
- in_ready  out  1  parser can accept a character
- out_valid  out  1  parsed token available
- out_ready  in  1  downstream accepts token
- out_value  out  WIDTH  parsed value (low WIDTH bits)
- out_ndigits  out  CW  hex digits in token, saturating at 2^CW-1
- out_overflow  out  1  token had more than WIDTH/4 significant digits
- err  out  1  one-cycle pulse: token discarded

## Operation
- Character classes:
  - Digit: '0'-'9', 'A'-'F', 'a'-'f'.
  - Delimiter: space (0x20), tab (0x09), LF (0x0A), CR (0x0D), ','.
  - Anything else is invalid.
- A character is accepted when in_valid && in_ready.
- FSM states: IDLE, ACC, SKIP, HOLD. The reset state is IDLE.
- IDLE:
  - Digit: acc = nibble, ndigits = 1, overflow = 0, go to ACC.
  - Delimiter: ignored.
  - Invalid: err pulse, go to SKIP.
- ACC:
  - Digit: acc = {acc[WIDTH-5:0], nibble}, ndigits++ (saturating).
  - overflow is set when a digit is accepted while ndigits >= WIDTH/4 and the current acc[WIDTH-1:WIDTH-4] != 0. The flag stays set until the token ends. Leading zeros therefore never cause overflow.
  - Delimiter: latch out_value, out_ndigits and out_overflow, then go to HOLD.
  - Invalid: err pulse, go to SKIP.
- SKIP: discard characters until a delimiter is accepted, then go to IDLE. No err pulse is generated while in SKIP.
- HOLD:
  - out_valid = 1 and in_ready = 0.
  - On out_valid && out_ready, go to IDLE.
- in_ready = 1 in IDLE, ACC and SKIP.
- out_value, out_ndigits and out_overflow are stable throughout HOLD. Outside HOLD they hold their last token.
- Reset values: out_valid 0, out_value 0, out_ndigits 0, out_overflow 0, err 0, in_ready 1 (IDLE).
- A reset mid-token drops the partial token without emitting anything.

## Timing
- All outputs are registered.
- A delimiter accepted at cycle N gives out_valid = 1 from cycle N+1.
- Token handshake at cycle M gives in_ready = 1 at cycle M+1. The maximum token rate is therefore one per (digits + 2) cycles.
- An invalid character accepted at cycle N gives err = 1 during cycle N+1 only.
- in_ready does not depend combinationally on out_ready.
- Back-to-back delimiters cost one cycle each and produce nothing.

## Configuration
- Macro ASCII_HEX_PREFIX_EN.
- Defined:
  - In ACC, 'x'/'X' is accepted as a prefix when ndigits == 1, acc == 0 and no prefix has been taken yet. Acceptance sets a prefix flag, clears ndigits and leaves acc = 0.
  - A delimiter arriving with the prefix flag set and ndigits == 0 (a bare "0x") is treated as an err pulse and a return to IDLE. No token is produced.
  - A second 'x' in the same token is invalid and leads to SKIP.
- Undefined: 'x'/'X' is an invalid character.

## Test plan
- "1A3f " → one token: value 0x1A3F, ndigits 4, overflow 0. err is never asserted.
- WIDTH=32, "123456789\n" → value 0x23456789, ndigits 9, overflow 1. Separately, "000000000ABCDEF1," → value 0xABCDEF1, overflow 0.
- "12G4 5 " → err pulse 1 cycle after 'G' is accepted, no token for "12G4", then token value 5, ndigits 1.
- Backpressure: hold out_ready = 0 for 10 cycles after "FF ". Required: out_valid and value 0xFF held stable and in_ready = 0 for those 10 cycles; in_ready = 1 the cycle after the handshake; the next token "7," → 7.
- Assert rst_n low mid-token "AB" and release, then send "C ". Required: all outputs at reset values during reset, then a single token 0xC.
- Prefix check, "0x7f," and "0x,":
  - With ASCII_HEX_PREFIX_EN: "0x7f," gives 0x7F with ndigits 2; "0x," gives an err pulse and no token.
  - Without the macro: both inputs give an err pulse and no token.
